rv32_alu: RTL and testbench
===========================

Name: rv32_alu

Overview:
- Execute-stage ALU for the RV32IM core. Computes the RV32I integer results, RV32M multiply/divide results and address sums (load, store, JALR, AUIPC), selected directly by the raw opcode/funct3/funct7 instruction fields.
- Single-cycle datapath with a registered output: the result is valid one clock after the operands are captured.
- No architectural flags; result only.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/fields valid this cycle.
- a  input  32  operand A: rs1, or PC for AUIPC.
- b  input  32  operand B: rs2 or sign-extended immediate; U-type immediate already shifted left by 12.
- opcode  input  7  instruction opcode field.
- funct3  input  3  instruction funct3 field.
- funct7  input  7  instruction funct7 field.
- result  output  32  registered result.
- out_valid  output  1  result is valid; registered copy of in_valid.

Behaviour:
- Reset:
  - rst high clears result to 0x00000000 and out_valid to 0 immediately.
  - Reset asserted mid-operation discards the pending result.
- Timing:
  - On each rising clk with rst low: result <= f(a,b,opcode,funct3,funct7); out_valid <= in_valid.
  - Latency is 1 cycle; throughput is 1 operation per cycle.
  - When in_valid=0, result holds its previous value.
- Shifts: shift amount is b[4:0]; upper bits of b are ignored.
- OP_REG (0x33), funct7=0x01 (RV32M):
  - funct3 0 MUL: low 32 bits of a*b.
  - funct3 1 MULH: high 32 bits of signed*signed.
  - funct3 2 MULHSU: high 32 bits of signed a * unsigned b.
  - funct3 3 MULHU: high 32 bits of unsigned*unsigned.
  - funct3 4 DIV: signed quotient, truncated toward zero.
  - funct3 5 DIVU: unsigned quotient.
  - funct3 6 REM: signed remainder; sign follows the dividend.
  - funct3 7 REMU: unsigned remainder.
  - Division by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - All 64-bit products and the divide are combinational within the cycle.
- OP_REG (0x33), any funct7 other than 0x01 (base integer ops; funct7[5] selects SUB/SRA):
  - funct3 0: ADD, or SUB when funct7[5]=1.
  - funct3 1: SLL.
  - funct3 2: SLT (signed), result 1 or 0.
  - funct3 3: SLTU (unsigned), result 1 or 0.
  - funct3 4: XOR.
  - funct3 5: SRL, or SRA when funct7[5]=1.
  - funct3 6: OR.
  - funct3 7: AND.
- OP_IMM (0x13):
  - Same funct3 map as OP_REG, except funct3 0 is always ADD (funct7 ignored).
  - funct3 5 uses funct7[5] to select SRAI over SRLI.
- LUI (0x37): result = b.
- AUIPC (0x17), LOAD (0x03), STORE (0x23), JALR (0x67):
  - result = a + b.
  - JALR bit-0 clearing is not performed here.
- Any other opcode: result = 0.
- Arithmetic:
  - All add/sub wraps modulo 2^32.
  - SRA/SRAI replicate a[31].

Test Plan:
- Reset: assert rst while result is nonzero -> result=0 and out_valid=0 immediately, without waiting for a clock edge. Deassert rst, apply in_valid=1, ADD 10+5 -> after 1 clk result=15, out_valid=1.
- Base arithmetic and compare:
  - ADD 0xFFFFFFFF+1 -> 0; SUB 0-1 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF,0 -> 1; SLTU 0xFFFFFFFF,0 -> 0.
  - ADDI with funct7=0x20, 100+0xFFFFFFFF -> 99.
- Shifts:
  - SLL 1<<31 -> 0x80000000; SRL 0x80000000>>1 -> 0x40000000.
  - SRA 0xF0000000>>4 -> 0xFF000000; SRAI 0xFFFFFFFC>>1 -> 0xFFFFFFFE.
- Pass-through and address sums: LUI b=0xDEAD0000 -> 0xDEAD0000; AUIPC 0x1000+0x12345000 -> 0x12346000; JALR 0x30000000+8 -> 0x30000008.
- Multiply:
  - MUL 7*6 -> 42.
  - MULH -1000*1000 -> 0xFFFFFFFF.
  - MULHSU 0xFFFFFFFF*0x80000000 -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Divide corners and unknown opcode:
  - DIV 42/0 -> 0xFFFFFFFF; REM 43%0 -> 43.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - REMU 0xFFFFFFFF%10 -> 5.
  - opcode 0x7F -> 0.

Source files
------------

// File: rtl/rv32_alu.sv
// rv32_alu: RV32IM execute-stage ALU with a registered result.
// Decodes the raw opcode/funct3/funct7 fields. The result is valid one clock after capture.
module rv32_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic [XLEN-1:0] result,
    output logic            out_valid
);
    localparam logic [6:0] OP_REG = 7'h33;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] JALR   = 7'h67;

    logic [4:0]        shamt;
    logic              alt, signed_a, signed_b, div_signed, b_zero;
    logic [XLEN-1:0]   sum, diff, sra, base, md, alu_out;
    logic [XLEN-1:0]   abs_a, abs_b, uq, ur, quo, rem;
    logic [2*XLEN-1:0] prod;

    assign shamt = b[4:0];
    assign alt   = funct7[5];
    assign sum   = a + b;
    assign diff  = a - b;
    assign sra   = $signed(a) >>> shamt;

    // The low product half does not depend on the extension, so one multiplier serves MUL and all MULH variants.
    assign signed_a = funct3 == 3'd1 || funct3 == 3'd2;
    assign signed_b = funct3 == 3'd1;
    assign prod     = {{XLEN{signed_a & a[XLEN-1]}}, a} * {{XLEN{signed_b & b[XLEN-1]}}, b};

    // Divide magnitudes and fix the signs afterwards. 0x80000000 / -1 then yields 0x80000000 rem 0 with no special case.
    assign div_signed = !funct3[0];
    assign b_zero     = b == '0;
    assign abs_a      = div_signed && a[XLEN-1] ? -a : a;
    assign abs_b      = div_signed && b[XLEN-1] ? -b : b;
    assign uq         = abs_a / abs_b;
    assign ur         = abs_a % abs_b;
    assign quo        = b_zero ? '1 : div_signed && (a[XLEN-1] ^ b[XLEN-1]) ? -uq : uq;
    assign rem        = b_zero ? a : div_signed && a[XLEN-1] ? -ur : ur;

    assign md = funct3[2] ? (funct3[1] ? rem : quo)
                          : (funct3[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_comb begin
        base = '0;
        case (funct3)
            3'd0: base = opcode == OP_REG && alt ? diff : sum;
            3'd1: base = a << shamt;
            3'd2: base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'd3: base = {{(XLEN-1){1'b0}}, a < b};
            3'd4: base = a ^ b;
            3'd5: base = alt ? sra : a >> shamt;
            3'd6: base = a | b;
            3'd7: base = a & b;
            default: base = '0;
        endcase
    end

    always_comb begin
        alu_out = '0;
        if (opcode == OP_REG && funct7 == 7'h01) alu_out = md;
        else if (opcode == OP_REG || opcode == OP_IMM) alu_out = base;
        else if (opcode == LUI) alu_out = b;
        else if (opcode inside {AUIPC, LOAD, STORE, JALR}) alu_out = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) result <= alu_out;
        end
    end
endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: self-checking bench for rv32_alu, using directed corner cases and
// random operations compared against a behavioural model.
module tb_rv32_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] result;
    logic        out_valid;
    int          checks = 0, errors = 0;

    typedef struct {
        string       name;
        logic [31:0] a, b;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] exp;
    } vec_t;
    vec_t dir[$];

    rv32_alu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .result(result), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int          sx = x, sy = y;
        longint      ps;
        logic [63:0] pu;
        int          sh = int'(y[4:0]);
        logic        ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
        if (op == 7'h33 && f7 == 7'h01) begin
            case (f3)
                3'd0: return x * y;
                3'd1: begin ps = longint'(sx) * longint'(sy); return ps[63:32]; end
                3'd2: begin ps = longint'(sx) * longint'({32'b0, y}); return ps[63:32]; end
                3'd3: begin pu = {32'b0, x} * {32'b0, y}; return pu[63:32]; end
                3'd4: return y == 0 ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sx / sy);
                3'd5: return y == 0 ? 32'hFFFFFFFF : x / y;
                3'd6: return y == 0 ? x : ovf ? 32'h0 : 32'(sx % sy);
                default: return y == 0 ? x : x % y;
            endcase
        end
        if (op == 7'h33 || op == 7'h13) begin
            case (f3)
                3'd0: return (op == 7'h33 && f7[5]) ? x - y : x + y;
                3'd1: return x << sh;
                3'd2: return (sx < sy) ? 32'd1 : 32'd0;
                3'd3: return (x < y) ? 32'd1 : 32'd0;
                3'd4: return x ^ y;
                3'd5: return f7[5] ? 32'(sx >>> sh) : x >> sh;
                3'd6: return x | y;
                default: return x & y;
            endcase
        end
        if (op == 7'h37) return y;
        if (op == 7'h17 || op == 7'h03 || op == 7'h23 || op == 7'h67) return x + y;
        return 32'h0;
    endfunction

    task automatic set_in(input logic [31:0] x, input logic [31:0] y, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7, input logic v);
        a = x; b = y; opcode = op; funct3 = f3; funct7 = f7; in_valid = v;
    endtask

    task automatic rand_op(output logic [31:0] x, output logic [31:0] y, output logic [6:0] op,
                           output logic [2:0] f3, output logic [6:0] f7);
        logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hA};
        logic [6:0]  ops[9] = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h67};
        logic [6:0]  f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h01};
        x = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
        y = ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : $urandom;
        op = ($urandom_range(15) == 0) ? 7'($urandom) : ops[$urandom_range(8)];
        f3 = 3'($urandom);
        f7 = ($urandom_range(7) == 0) ? 7'($urandom) : f7s[$urandom_range(3)];
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (result !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: result=%h out_valid=%b, required 00000000/0", result, out_valid);
        end
        @(negedge clk); rst = 1'b0;
        set_in(32'd3, 32'd4, 7'h33, 3'd0, 7'h00, 1'b1);
        @(negedge clk);
        set_in(32'd0, 32'd0, 7'h33, 3'd0, 7'h00, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: result=%h out_valid=%b, required 00000000/0", result, out_valid);
        end
        @(negedge clk); rst = 1'b0;
        set_in(32'd10, 32'd5, 7'h33, 3'd0, 7'h00, 1'b1);
        @(negedge clk);
        checks++;
        if (result !== 32'd15 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_add: result=%h out_valid=%b, required 0000000f/1", result, out_valid);
        end
    endtask

    task automatic test_reset_midop;
        set_in(32'h11, 32'h22, 7'h33, 3'd0, 7'h00, 1'b1);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_in(32'h0, 32'h0, 7'h33, 3'd0, 7'h00, 1'b0);
        @(negedge clk);
        checks++;
        if (result !== 32'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop: result=%h out_valid=%b, required 00000000/0", result, out_valid);
        end
    endtask

    task automatic test_directed;
        foreach (dir[i]) begin
            set_in(dir[i].a, dir[i].b, dir[i].op, dir[i].f3, dir[i].f7, 1'b1);
            @(negedge clk);
            checks++;
            if (result !== dir[i].exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s: result=%h out_valid=%b, required %h/1", dir[i].name, result, out_valid, dir[i].exp);
            end
        end
    endtask

    task automatic test_hold;
        logic [31:0] exp;
        set_in(32'h1234, 32'h1111, 7'h33, 3'd4, 7'h00, 1'b1);
        exp = 32'h1234 ^ 32'h1111;
        @(negedge clk);
        set_in(32'hFFFF, 32'h1, 7'h33, 3'd0, 7'h00, 1'b0);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (result !== exp || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold: result=%h out_valid=%b, required %h/0", result, out_valid, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x, y, exp_q[$];
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        for (int i = 0; i <= 400; i++) begin
            if (i > 0) begin
                checks++;
                if (result !== exp_q[0] || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL random_op%0d: result=%h out_valid=%b, required %h/1 (a=%h b=%h op=%h f3=%0d f7=%h)",
                             i - 1, result, out_valid, exp_q[0], a, b, opcode, funct3, funct7);
                end
                void'(exp_q.pop_front());
            end
            if (i == 400) break;
            rand_op(x, y, op, f3, f7);
            set_in(x, y, op, f3, f7, 1'b1);
            exp_q.push_back(model(x, y, op, f3, f7));
            @(negedge clk);
        end
        set_in(32'h0, 32'h0, 7'h0, 3'd0, 7'h0, 1'b0);
    endtask

    task automatic add_vec(input string n, input logic [31:0] x, input logic [31:0] y, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] e);
        vec_t v;
        v.name = n; v.a = x; v.b = y; v.op = op; v.f3 = f3; v.f7 = f7; v.exp = e;
        dir.push_back(v);
    endtask

    initial begin
        add_vec("add_wrap",  32'hFFFFFFFF, 32'h1,        7'h33, 3'd0, 7'h00, 32'h0);
        add_vec("sub_wrap",  32'h0,        32'h1,        7'h33, 3'd0, 7'h20, 32'hFFFFFFFF);
        add_vec("slt",       32'hFFFFFFFF, 32'h0,        7'h33, 3'd2, 7'h00, 32'h1);
        add_vec("sltu",      32'hFFFFFFFF, 32'h0,        7'h33, 3'd3, 7'h00, 32'h0);
        add_vec("addi_f7",   32'd100,      32'hFFFFFFFF, 7'h13, 3'd0, 7'h20, 32'd99);
        add_vec("sll31",     32'h1,        32'd31,       7'h33, 3'd1, 7'h00, 32'h80000000);
        add_vec("sll_hi_b",  32'h1,        32'h21,       7'h33, 3'd1, 7'h00, 32'h2);
        add_vec("srl",       32'h80000000, 32'd1,        7'h33, 3'd5, 7'h00, 32'h40000000);
        add_vec("sra",       32'hF0000000, 32'd4,        7'h33, 3'd5, 7'h20, 32'hFF000000);
        add_vec("srai",      32'hFFFFFFFC, 32'd1,        7'h13, 3'd5, 7'h20, 32'hFFFFFFFE);
        add_vec("lui",       32'h5,        32'hDEAD0000, 7'h37, 3'd0, 7'h00, 32'hDEAD0000);
        add_vec("auipc",     32'h1000,     32'h12345000, 7'h17, 3'd0, 7'h00, 32'h12346000);
        add_vec("jalr",      32'h30000000, 32'd8,        7'h67, 3'd0, 7'h00, 32'h30000008);
        add_vec("mul",       32'd7,        32'd6,        7'h33, 3'd0, 7'h01, 32'd42);
        add_vec("mulh",      32'hFFFFFC18, 32'd1000,     7'h33, 3'd1, 7'h01, 32'hFFFFFFFF);
        add_vec("mulhsu",    32'hFFFFFFFF, 32'h80000000, 7'h33, 3'd2, 7'h01, 32'hFFFFFFFF);
        add_vec("mulhu",     32'hFFFFFFFF, 32'hFFFFFFFF, 7'h33, 3'd3, 7'h01, 32'hFFFFFFFE);
        add_vec("div_zero",  32'd42,       32'h0,        7'h33, 3'd4, 7'h01, 32'hFFFFFFFF);
        add_vec("rem_zero",  32'd43,       32'h0,        7'h33, 3'd6, 7'h01, 32'd43);
        add_vec("div_ovf",   32'h80000000, 32'hFFFFFFFF, 7'h33, 3'd4, 7'h01, 32'h80000000);
        add_vec("rem_ovf",   32'h80000000, 32'hFFFFFFFF, 7'h33, 3'd6, 7'h01, 32'h0);
        add_vec("remu",      32'hFFFFFFFF, 32'd10,       7'h33, 3'd7, 7'h01, 32'd5);
        add_vec("div_neg",   32'hFFFFFFF9, 32'd2,        7'h33, 3'd4, 7'h01, 32'hFFFFFFFD);
        add_vec("rem_neg",   32'hFFFFFFF9, 32'd2,        7'h33, 3'd6, 7'h01, 32'hFFFFFFFF);
        add_vec("unknown",   32'h1234,     32'h5678,     7'h7F, 3'd0, 7'h00, 32'h0);
        test_reset;
        test_directed;
        test_hold;
        test_reset_midop;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
